data_stack: RTL
===============

// Module: data_stack
// PURPOSE
//  Operand stack for the brus16 core. Sits directly upstream of the ALU.
//  Presents NOS as ALU operand a and TOS as operand b, both combinationally.
//  Accepts the ALU result back on alu_out and retires binary ops in one cycle:
//  it pops two entries and pushes one.
//  The decode stage drives one stack op per cycle.
// PARAMETERS
//  DEPTH    16  number of 16-bit stack entries; must be >= 2
//  SP_W     5   depth-counter width, set to $clog2(DEPTH+1)
// PORTS
//  clk        in   1     system clock; all state updates on rising edge
//  rst_n      in   1     synchronous reset, active low, sampled on rising clk
//  op         in   3     0=NOP 1=PUSH 2=POP 3=POP2 4=BINOP 5=DUP 6/7=NOP
//  push_data  in   16    value pushed by PUSH
//  alu_out    in   16    ALU result, written back by BINOP
//  a          out  16    NOS = mem[sp-2] when depth>=2, else 16'h0
//  b          out  16    TOS = mem[sp-1] when depth>=1, else 16'h0
//  depth      out  SP_W  current entry count, 0..DEPTH
//  empty      out  1     depth==0
//  full       out  1     depth==DEPTH
//  overflow   out  1     sticky: an illegal push was attempted
//  underflow  out  1     sticky: an illegal pop was attempted
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge):
//    - depth=0, overflow=0, underflow=0, so a=b=0, empty=1, full=0.
//    - Array contents are not reset.
//    - Reset overrides any op in the same cycle, including mid-sequence.
//  - a, b, empty and full are combinational from depth and the array. The ALU output is therefore valid in the same cycle.
//  - PUSH: if depth<DEPTH, mem[depth]<=push_data and depth+1. Otherwise there is no change and overflow<=1.
//  - DUP: if 1<=depth<DEPTH, mem[depth]<=TOS and depth+1.
//    - depth==0: no change, underflow<=1.
//    - depth==DEPTH: no change, overflow<=1.
//  - POP: if depth>=1, depth-1. Otherwise no change and underflow<=1.
//  - POP2 (e.g. STORE): if depth>=2, depth-2. Otherwise no change and underflow<=1.
//  - BINOP: if depth>=2, mem[depth-2]<=alu_out and depth-1.
//    - Net effect: a and b are replaced by the result, now TOS.
//    - Otherwise no change and underflow<=1. alu_out is ignored.
//  - All ops take 1 cycle. New a/b are visible immediately after the edge, so back-to-back ops need no stall.
//  - Rejected ops leave depth and the array completely unchanged. They are not partially executed.
//  - overflow and underflow stay set until reset. Later legal ops still execute normally.
//  - Popped entries are not cleared. A later push overwrites them.
//  - depth never wraps: it is bounded to 0..DEPTH by the rejection rules.
//  - Opcodes 6 and 7 behave as NOP. They raise no flags.
// TESTING
//  1. Reset, then PUSH 16'h0003 and PUSH 16'hFFFE.
//     -> depth=2, a=16'h0003, b=16'hFFFE, empty=0.
//  2. From 1, BINOP with alu_out=16'h0001.
//     -> depth=1, b=16'h0001, a=0, no flags.
//  3. Push 16 values 1..16, then PUSH 16'hBEEF.
//     -> full=1, depth=16, b=16'h0010, overflow=1, top entry unchanged.
//  4. Empty stack: POP. Then PUSH 16'h0007 and POP2.
//     -> underflow=1, depth stays 1, b=16'h0007.
//     -> Then PUSH 16'h0009 and POP2 -> depth=0, flags unchanged.
//  5. depth=1 (TOS=16'h00AA): DUP.
//     -> depth=2, a=b=16'h00AA.
//     -> BINOP at depth=1 -> underflow=1, depth=1.
//  6. depth=5 with overflow=1: assert rst_n=0 in the same cycle as a PUSH.
//     -> Next cycle depth=0, flags=0, a=b=0.
//     -> Opcode 7 afterwards changes nothing.

Source files
------------

// File: rtl/data_stack.sv
// Operand stack feeding the ALU: NOS/TOS are presented combinationally as a/b,
// and BINOP folds the ALU result back into the stack in a single cycle.
module data_stack #(
    parameter int DEPTH = 16,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      op,
    input  logic [15:0]     push_data,
    input  logic [15:0]     alu_out,
    output logic [15:0]     a,
    output logic [15:0]     b,
    output logic [SP_W-1:0] depth,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_POP2  = 3'd3,
        OP_BINOP = 3'd4,
        OP_DUP   = 3'd5
    } op_e;

    logic [15:0]     mem_q [DEPTH];
    logic [SP_W-1:0] depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [15:0]     wdata;

    logic            has1, has2, is_full;
    logic [AW-1:0]   top_idx, tos_idx, nos_idx;

    assign has1    = (depth_q >= SP_W'(1));
    assign has2    = (depth_q >= SP_W'(2));
    assign is_full = (depth_q == SP_W'(DEPTH));
    // Indices are only used when the matching depth guard holds, so truncation is safe.
    assign top_idx = AW'(depth_q);
    assign tos_idx = AW'(depth_q - SP_W'(1));
    assign nos_idx = AW'(depth_q - SP_W'(2));

    assign a         = has2 ? mem_q[nos_idx] : '0;
    assign b         = has1 ? mem_q[tos_idx] : '0;
    assign depth     = depth_q;
    assign empty     = !has1;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    waddr   = top_idx;
                    wdata   = push_data;
                    depth_d = depth_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_DUP: begin
                if (!has1) begin
                    unf_d = 1'b1;
                end else if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = top_idx;
                    wdata   = mem_q[tos_idx];
                    depth_d = depth_q + SP_W'(1);
                end
            end
            OP_POP: begin
                if (has1) depth_d = depth_q - SP_W'(1);
                else      unf_d   = 1'b1;
            end
            OP_POP2: begin
                if (has2) depth_d = depth_q - SP_W'(2);
                else      unf_d   = 1'b1;
            end
            OP_BINOP: begin
                if (has2) begin
                    we      = 1'b1;
                    waddr   = nos_idx;
                    wdata   = alu_out;
                    depth_d = depth_q - SP_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Array is not reset, but a write is still suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && we) mem_q[waddr] <= wdata;
    end

endmodule
